// File: rtl/ghash_ctrl.sv
// ---------------------------------------------------------------------------
// ghash_ctrl -- GHASH sequencer driving an external gfmul_v2 multiplier.
//
// Computes Y_i = (Y_{i-1} ^ X_i) * H over a stream of 128-bit AAD/ciphertext
// blocks and returns the final Y as the GHASH tag.
//
// Build option:
//   LEN_BLOCK_EN  when defined, the block counts AAD/CT bytes and appends the
//                 GCM length block {lenA_bits, lenC_bits} itself. When
//                 undefined, the source supplies the length block as the
//                 last data block, and iBlock_type / iBlock_nbytes are unused.
//
// Parameters:
//   LEN_W        width of the internal byte counters (LEN_BLOCK_EN only)
//   GAP_CYCLES   cycles the multiplier valids stay low between operations
//
// Ports:
//   iClk, iRst          clock, synchronous active-high reset
//   iHashkey(_valid)    hash key H, captured only while idle
//   iBlock*             block stream: data, valid, last, type, byte count
//   oBlock_ready        block accepted when iBlock_valid && oBlock_ready
//   oMul_a(_valid)      multiplier operand Y ^ X
//   oMul_h(_valid)      multiplier operand H (registered copy)
//   iMul_result(_valid) multiplier product
//   oTag, oTag_valid    final GHASH value and its one-cycle strobe
//   oBusy               high from key capture until the tag strobe
// ---------------------------------------------------------------------------
module ghash_ctrl #(
    parameter int LEN_W      = 32,
    parameter int GAP_CYCLES = 1
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic [127:0] iHashkey,
    input  logic         iHashkey_valid,
    input  logic [127:0] iBlock,
    input  logic         iBlock_valid,
    input  logic         iBlock_last,
    input  logic         iBlock_type,
    input  logic [4:0]   iBlock_nbytes,
    output logic         oBlock_ready,
    output logic [127:0] oMul_a,
    output logic         oMul_a_valid,
    output logic [127:0] oMul_h,
    output logic         oMul_h_valid,
    input  logic [127:0] iMul_result,
    input  logic         iMul_result_valid,
    output logic [127:0] oTag,
    output logic         oTag_valid,
    output logic         oBusy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_MUL,
        S_GAP,
`ifdef LEN_BLOCK_EN
        S_LEN,
`endif
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] h_q, h_d;
    logic [127:0] y_q, y_d;
    logic [127:0] mul_a_q, mul_a_d;
    logic         mul_valid_q, mul_valid_d;
    logic         ready_q, ready_d;
    logic         busy_q, busy_d;
    logic [127:0] tag_q, tag_d;
    logic         tag_valid_q, tag_valid_d;
    logic         last_q, last_d;
    // Set during the first MUL cycle, where a result strobe is stale.
    logic         first_q, first_d;
    logic [GAP_W-1:0] gap_q, gap_d;

`ifdef LEN_BLOCK_EN
    logic [LEN_W-1:0] aad_q, aad_d;
    logic [LEN_W-1:0] ct_q, ct_d;
    // Set once the length block has been multiplied in.
    logic             len_q, len_d;
    logic [4:0]       nb_eff;
    logic [63:0]      aad_bits;
    logic [63:0]      ct_bits;

    // A byte count of 0 encodes a full 16-byte block.
    assign nb_eff   = (iBlock_nbytes == 5'd0) ? 5'd16 : iBlock_nbytes;
    assign aad_bits = 64'(aad_q) << 3;
    assign ct_bits  = 64'(ct_q) << 3;
`else
    logic unused_cfg;
    assign unused_cfg = ^{iBlock_type, iBlock_nbytes};
`endif

    // NOTE: every variable gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        y_d         = y_q;
        mul_a_d     = mul_a_q;
        mul_valid_d = mul_valid_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        tag_d       = tag_q;
        tag_valid_d = 1'b0;
        last_d      = last_q;
        first_d     = first_q;
        gap_d       = gap_q;
`ifdef LEN_BLOCK_EN
        aad_d       = aad_q;
        ct_d        = ct_q;
        len_d       = len_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (iHashkey_valid) begin
                    h_d     = iHashkey;
                    y_d     = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_ACCEPT;
`ifdef LEN_BLOCK_EN
                    aad_d   = '0;
                    ct_d    = '0;
                    len_d   = 1'b0;
`endif
                end
            end

            S_ACCEPT: begin
                if (iBlock_valid && ready_q) begin
                    mul_a_d     = y_q ^ iBlock;
                    last_d      = iBlock_last;
                    ready_d     = 1'b0;
                    mul_valid_d = 1'b1;
                    first_d     = 1'b1;
                    state_d     = S_MUL;
`ifdef LEN_BLOCK_EN
                    if (iBlock_type) begin
                        ct_d = ct_q + LEN_W'(nb_eff);
                    end else begin
                        aad_d = aad_q + LEN_W'(nb_eff);
                    end
`endif
                end
            end

            S_MUL: begin
                first_d = 1'b0;
                if (iMul_result_valid && !first_q) begin
                    y_d         = iMul_result;
                    mul_valid_d = 1'b0;
                    gap_d       = GAP_W'(GAP_CYCLES - 1);
                    state_d     = S_GAP;
                end
            end

            S_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (!last_q) begin
                    ready_d = 1'b1;
                    state_d = S_ACCEPT;
`ifdef LEN_BLOCK_EN
                end else if (!len_q) begin
                    state_d = S_LEN;
`endif
                end else begin
                    tag_d       = y_q;
                    tag_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_DONE;
                end
            end

`ifdef LEN_BLOCK_EN
            S_LEN: begin
                mul_a_d     = y_q ^ {aad_bits, ct_bits};
                len_d       = 1'b1;
                mul_valid_d = 1'b1;
                first_d     = 1'b1;
                state_d     = S_MUL;
            end
`endif

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= S_IDLE;
            h_q         <= '0;
            y_q         <= '0;
            mul_a_q     <= '0;
            mul_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            last_q      <= 1'b0;
            first_q     <= 1'b0;
            gap_q       <= '0;
`ifdef LEN_BLOCK_EN
            aad_q       <= '0;
            ct_q        <= '0;
            len_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            y_q         <= y_d;
            mul_a_q     <= mul_a_d;
            mul_valid_q <= mul_valid_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            last_q      <= last_d;
            first_q     <= first_d;
            gap_q       <= gap_d;
`ifdef LEN_BLOCK_EN
            aad_q       <= aad_d;
            ct_q        <= ct_d;
            len_q       <= len_d;
`endif
        end
    end

    assign oBlock_ready = ready_q;
    assign oMul_a       = mul_a_q;
    assign oMul_a_valid = mul_valid_q;
    assign oMul_h       = h_q;
    assign oMul_h_valid = mul_valid_q;
    assign oTag         = tag_q;
    assign oTag_valid   = tag_valid_q;
    assign oBusy        = busy_q;

endmodule

// File: tb/tb_ghash_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ghash_ctrl -- directed bench for ghash_ctrl with a behavioural gfmul_v2
// responder of programmable latency.
// ---------------------------------------------------------------------------
module tb_ghash_ctrl;

    localparam int GAP = 2;

    localparam logic [127:0] H1   = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
    localparam logic [127:0] C1   = 128'h0388DACE60B6A392F328C2B971B2FE78;
    localparam logic [127:0] Y1   = 128'h5E2EC746917062882C85B0685353DEB7;
    localparam logic [127:0] TAG1 = 128'hF38CBB1AD69223DCC3457AE5B6B0F885;
    localparam logic [127:0] LEN1 = 128'h80;
    localparam logic [127:0] H2   = 128'h73A23D80121DE2D5A850253FCF43120E;
    localparam logic [127:0] A1   = 128'hD609B1F056637A0D46DF998D88E52E00;
    localparam logic [127:0] Y2A  = 128'h9CABBD91899C1413AA7AD629C1DF12CD;
    localparam logic [127:0] A2   = 128'hB2C2846512153524C0895E8100000000;
    localparam logic [127:0] Y2B  = 128'hB99ABF6BDBD18B8E148F8030F0686F28;
    localparam logic [127:0] JUNK = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;

    logic         iClk;
    logic         iRst;
    logic [127:0] iHashkey;
    logic         iHashkey_valid;
    logic [127:0] iBlock;
    logic         iBlock_valid;
    logic         iBlock_last;
    logic         iBlock_type;
    logic [4:0]   iBlock_nbytes;
    logic         oBlock_ready;
    logic [127:0] oMul_a;
    logic         oMul_a_valid;
    logic [127:0] oMul_h;
    logic         oMul_h_valid;
    logic [127:0] iMul_result;
    logic         iMul_result_valid;
    logic [127:0] oTag;
    logic         oTag_valid;
    logic         oBusy;

    ghash_ctrl #(.LEN_W(32), .GAP_CYCLES(GAP)) dut (
        .iClk              (iClk),
        .iRst              (iRst),
        .iHashkey          (iHashkey),
        .iHashkey_valid    (iHashkey_valid),
        .iBlock            (iBlock),
        .iBlock_valid      (iBlock_valid),
        .iBlock_last       (iBlock_last),
        .iBlock_type       (iBlock_type),
        .iBlock_nbytes     (iBlock_nbytes),
        .oBlock_ready      (oBlock_ready),
        .oMul_a            (oMul_a),
        .oMul_a_valid      (oMul_a_valid),
        .oMul_h            (oMul_h),
        .oMul_h_valid      (oMul_h_valid),
        .iMul_result       (iMul_result),
        .iMul_result_valid (iMul_result_valid),
        .oTag              (oTag),
        .oTag_valid        (oTag_valid),
        .oBusy             (oBusy)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Responder controls (written by the test sequence only).
    int           lat         = 1;
    logic         inject_late = 1'b0;
    logic [127:0] exp_h       = '0;

    // Responder observations (written by the responder only).
    logic [127:0] ops_a[$];
    int           gaps[$];
    int           hs       = 0;
    int           h_bad    = 0;
    int           hold_bad = 0;

    // GF(2^128) product in GCM bit order (bit 0 of the field = MSB here).
    function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z;
        logic [127:0] v;
        z = '0;
        v = y;
        for (int i = 0; i < 128; i++) begin
            if (x[127-i]) z = z ^ v;
            if (v[0]) v = (v >> 1) ^ {8'hE1, 120'h0};
            else      v = v >> 1;
        end
        return z;
    endfunction

    // gfmul_v2 model: result strobe 'lat' cycles after the first operand
    // cycle; also logs operands, idle gaps and block handshakes.
    initial begin : responder
        int           cnt;
        int           low_run;
        logic         prev_valid;
        logic [127:0] cur_a;
        cnt        = 0;
        low_run    = 1000;
        prev_valid = 1'b0;
        cur_a      = '0;
        iMul_result       = '0;
        iMul_result_valid = 1'b0;
        forever begin
            @(negedge iClk);
            if (oMul_h_valid !== oMul_a_valid) h_bad++;
            if (oMul_a_valid === 1'b1) begin
                if (!prev_valid) begin
                    ops_a.push_back(oMul_a);
                    gaps.push_back(low_run);
                    cur_a = oMul_a;
                end else if (oMul_a !== cur_a) begin
                    hold_bad++;
                end
                if (oMul_h !== exp_h) h_bad++;
                cnt++;
                low_run = 0;
                iMul_result       = gf_mul(oMul_a, oMul_h);
                iMul_result_valid = (cnt == lat + 1);
            end else begin
                cnt = 0;
                low_run++;
                iMul_result       = inject_late ? JUNK : '0;
                iMul_result_valid = inject_late;
            end
            if (iBlock_valid && oBlock_ready) hs++;
            prev_valid = oMul_a_valid;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    // ---- stimulus helpers (called at posedge + #1) ----

    task automatic start_msg(input logic [127:0] key);
        exp_h          = key;
        iHashkey       = key;
        iHashkey_valid = 1'b1;
        @(posedge iClk); #1;
        iHashkey_valid = 1'b0;
        n_cmp++;
        if (oBusy !== 1'b1 || oBlock_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL key_capture: busy=%b ready=%b, want busy=1 ready=1", oBusy, oBlock_ready);
        end
    endtask

    task automatic send_block(input logic [127:0] blk, input logic last, input logic typ,
                              input logic [4:0] nb, input logic hold);
        int t;
        iBlock        = blk;
        iBlock_last   = last;
        iBlock_type   = typ;
        iBlock_nbytes = nb;
        iBlock_valid  = 1'b1;
        t = 0;
        while (oBlock_ready !== 1'b1 && t < 300) begin
            @(posedge iClk); #1;
            t++;
        end
        if (oBlock_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles, want 1", oBlock_ready, t);
        end
        @(posedge iClk); #1;
        if (!hold || last) iBlock_valid = 1'b0;
        n_cmp++;
        if (oBlock_ready !== 1'b0 || oMul_a_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_edge: ready=%b mul_valid=%b, want ready=0 mul_valid=1",
                     oBlock_ready, oMul_a_valid);
        end
    endtask

    task automatic wait_tag(output logic [127:0] tag);
        int t;
        t = 0;
        while (oTag_valid !== 1'b1 && t < 500) begin
            @(posedge iClk); #1;
            t++;
        end
        n_cmp++;
        if (oTag_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL tag_timeout: tag_valid=%b after %0d cycles, want 1", oTag_valid, t);
            tag = 'x;
        end else begin
            tag = oTag;
            n_cmp++;
            if (oBusy !== 1'b0) begin
                n_bad++;
                $display("FAIL busy_at_tag: busy=%b, want 0", oBusy);
            end
            @(posedge iClk); #1;
            n_cmp++;
            if (oTag_valid !== 1'b0 || oTag !== tag) begin
                n_bad++;
                $display("FAIL tag_pulse: tag_valid=%b tag=%h, want 0 and held %h", oTag_valid, oTag, tag);
            end
        end
    endtask

    // T1 message; the length block is sent by the bench only when the
    // design does not generate it.
    task automatic run_t1(input logic [4:0] nb, output logic [127:0] tag);
        start_msg(H1);
`ifdef LEN_BLOCK_EN
        send_block(C1, 1'b1, 1'b1, nb, 1'b0);
`else
        send_block(C1, 1'b0, 1'b1, nb, 1'b0);
        send_block(LEN1, 1'b1, 1'b1, nb, 1'b0);
`endif
        wait_tag(tag);
    endtask

    // ---- tests ----

    task automatic test_reset();
        int hs0;
        iRst = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
        n_cmp++;
        if ({oBlock_ready, oMul_a_valid, oMul_h_valid, oTag_valid, oBusy} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: ready,a_v,h_v,tag_v,busy=%b, want 00000",
                     {oBlock_ready, oMul_a_valid, oMul_h_valid, oTag_valid, oBusy});
        end
        n_cmp++;
        if (oMul_a !== '0 || oMul_h !== '0 || oTag !== '0) begin
            n_bad++;
            $display("FAIL reset_data: a=%h h=%h tag=%h, want all 0", oMul_a, oMul_h, oTag);
        end
        iRst = 1'b0;
        // Blocks offered while idle must not be taken.
        hs0 = hs;
        iBlock       = C1;
        iBlock_valid = 1'b1;
        repeat (4) @(posedge iClk);
        #1;
        iBlock_valid = 1'b0;
        n_cmp++;
        if (hs != hs0 || oBlock_ready !== 1'b0 || oBusy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_no_accept: handshakes=%0d ready=%b busy=%b, want 0 0 0",
                     hs - hs0, oBlock_ready, oBusy);
        end
    endtask

    task automatic test_single_block();
        logic [127:0] tag;
        int idx;
        lat = 3;
        idx = ops_a.size();
        run_t1(5'd16, tag);
        n_cmp++;
        if (tag !== TAG1) begin
            n_bad++;
            $display("FAIL t1_tag: got %h, want %h", tag, TAG1);
        end
        n_cmp++;
        if (ops_a.size() != idx + 2) begin
            n_bad++;
            $display("FAIL t1_op_count: got %0d, want 2", ops_a.size() - idx);
        end else begin
            n_cmp++;
            if (ops_a[idx] !== C1) begin
                n_bad++;
                $display("FAIL t1_op0: got %h, want %h", ops_a[idx], C1);
            end
            // Second operand is Y1 ^ length block, whoever supplies it.
            n_cmp++;
            if (ops_a[idx+1] !== (Y1 ^ LEN1)) begin
                n_bad++;
                $display("FAIL t1_op1: got %h, want %h", ops_a[idx+1], Y1 ^ LEN1);
            end
        end
    endtask

    task automatic test_two_blocks_held();
        logic [127:0] tag;
        logic [127:0] exp_tag;
        int idx, hs0, hb0, min_gap;
        lat = 2;
        idx = ops_a.size();
        hs0 = hs;
        hb0 = hold_bad;
        start_msg(H2);
        send_block(A1, 1'b0, 1'b0, 5'd16, 1'b1);
        send_block(A2, 1'b1, 1'b0, 5'd12, 1'b1);
        wait_tag(tag);
`ifdef LEN_BLOCK_EN
        exp_tag = gf_mul(Y2B ^ {64'd224, 64'd0}, H2);
`else
        exp_tag = Y2B;
`endif
        n_cmp++;
        if (tag !== exp_tag) begin
            n_bad++;
            $display("FAIL t2_tag: got %h, want %h", tag, exp_tag);
        end
        n_cmp++;
        if (ops_a.size() < idx + 2) begin
            n_bad++;
            $display("FAIL t2_op_count: got %0d, want >= 2", ops_a.size() - idx);
        end else begin
            n_cmp++;
            if (ops_a[idx] !== A1) begin
                n_bad++;
                $display("FAIL t2_op0: got %h, want %h", ops_a[idx], A1);
            end
            n_cmp++;
            if (ops_a[idx+1] !== (Y2A ^ A2)) begin
                n_bad++;
                $display("FAIL t2_op1: got %h, want %h", ops_a[idx+1], Y2A ^ A2);
            end
`ifdef LEN_BLOCK_EN
            n_cmp++;
            if (ops_a.size() != idx + 3 || ops_a[idx+2] !== (Y2B ^ {64'd224, 64'd0})) begin
                n_bad++;
                $display("FAIL t2_len_op: count=%0d, want 3 with len operand", ops_a.size() - idx);
            end
`endif
            min_gap = 1000;
            for (int k = idx + 1; k < gaps.size(); k++) begin
                if (gaps[k] < min_gap) min_gap = gaps[k];
            end
            n_cmp++;
            if (min_gap < GAP) begin
                n_bad++;
                $display("FAIL t3_gap: min idle gap %0d cycles, want >= %0d", min_gap, GAP);
            end
        end
        n_cmp++;
        if (hs - hs0 != 2) begin
            n_bad++;
            $display("FAIL t3_handshakes: got %0d, want 2", hs - hs0);
        end
        n_cmp++;
        if (hold_bad != hb0) begin
            n_bad++;
            $display("FAIL operand_hold: %0d changes during MUL, want 0", hold_bad - hb0);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [127:0] tag;
        lat = 20;
        start_msg(H1);
`ifdef LEN_BLOCK_EN
        send_block(C1, 1'b1, 1'b1, 5'd16, 1'b0);
`else
        send_block(C1, 1'b0, 1'b1, 5'd16, 1'b0);
`endif
        repeat (3) @(posedge iClk);
        #1;
        n_cmp++;
        if (oMul_a_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL t4_in_mul: mul_valid=%b, want 1", oMul_a_valid);
        end
        iRst = 1'b1;
        @(posedge iClk); #1;
        iRst = 1'b0;
        n_cmp++;
        if ({oBlock_ready, oMul_a_valid, oMul_h_valid, oTag_valid, oBusy} !== 5'b0 ||
            oMul_a !== '0 || oMul_h !== '0 || oTag !== '0) begin
            n_bad++;
            $display("FAIL t4_reset_outputs: flags=%b a=%h h=%h tag=%h, want all 0",
                     {oBlock_ready, oMul_a_valid, oMul_h_valid, oTag_valid, oBusy},
                     oMul_a, oMul_h, oTag);
        end
        inject_late = 1'b1;
        @(posedge iClk); #1;
        inject_late = 1'b0;
        @(posedge iClk); #1;
        n_cmp++;
        if ({oBlock_ready, oMul_a_valid, oTag_valid, oBusy} !== 4'b0 || oTag !== '0) begin
            n_bad++;
            $display("FAIL t4_late_result: flags=%b tag=%h, want 0000 and 0",
                     {oBlock_ready, oMul_a_valid, oTag_valid, oBusy}, oTag);
        end
        lat = 4;
        run_t1(5'd16, tag);
        n_cmp++;
        if (tag !== TAG1) begin
            n_bad++;
            $display("FAIL t4_recover_tag: got %h, want %h", tag, TAG1);
        end
    endtask

    task automatic test_key_change();
        logic [127:0] tag;
        int hb0;
        lat = 10;
        hb0 = h_bad;
        start_msg(H1);
`ifdef LEN_BLOCK_EN
        send_block(C1, 1'b1, 1'b1, 5'd16, 1'b0);
`else
        send_block(C1, 1'b0, 1'b1, 5'd16, 1'b0);
`endif
        iHashkey       = H2;
        iHashkey_valid = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
        iHashkey_valid = 1'b0;
        n_cmp++;
        if (oMul_h !== H1) begin
            n_bad++;
            $display("FAIL t5_h_held: got %h, want %h", oMul_h, H1);
        end
`ifndef LEN_BLOCK_EN
        send_block(LEN1, 1'b1, 1'b1, 5'd16, 1'b0);
`endif
        wait_tag(tag);
        n_cmp++;
        if (tag !== TAG1) begin
            n_bad++;
            $display("FAIL t5_tag: got %h, want %h", tag, TAG1);
        end
        n_cmp++;
        if (h_bad != hb0) begin
            n_bad++;
            $display("FAIL t5_h_operand: %0d bad H cycles, want 0", h_bad - hb0);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] tag_fast;
        logic [127:0] tag_slow;
        lat = 1;
        run_t1(5'd16, tag_fast);
        lat = 20;
        run_t1(5'd16, tag_slow);
        n_cmp++;
        if (tag_fast !== TAG1) begin
            n_bad++;
            $display("FAIL t6_fast_tag: got %h, want %h", tag_fast, TAG1);
        end
        n_cmp++;
        if (tag_slow !== TAG1) begin
            n_bad++;
            $display("FAIL t6_slow_tag: got %h, want %h", tag_slow, TAG1);
        end
`ifdef LEN_BLOCK_EN
        lat = 2;
        run_t1(5'd0, tag_fast);
        n_cmp++;
        if (tag_fast !== TAG1) begin
            n_bad++;
            $display("FAIL nbytes0_tag: got %h, want %h", tag_fast, TAG1);
        end
`endif
    endtask

    initial begin : main
        iRst           = 1'b1;
        iHashkey       = '0;
        iHashkey_valid = 1'b0;
        iBlock         = '0;
        iBlock_valid   = 1'b0;
        iBlock_last    = 1'b0;
        iBlock_type    = 1'b0;
        iBlock_nbytes  = 5'd0;
        @(posedge iClk); #1;

        test_reset();
        test_single_block();
        test_two_blocks_held();
        test_reset_mid_mul();
        test_key_change();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
